// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and default constants for the memory-port arbiter.
//   Exports the FSM state enum and default bus widths / segment bounds.
package mem_arb_pkg;

   localparam int MEM_ARB_ADDR_W = 32;
   localparam int MEM_ARB_DATA_W = 32;

   localparam logic [MEM_ARB_ADDR_W-1:0] MEM_ARB_INSTR_BASE = 32'h0000_0000;
   localparam logic [MEM_ARB_ADDR_W-1:0] MEM_ARB_INSTR_TOP  = 32'h0000_FFFF;
   localparam logic [MEM_ARB_ADDR_W-1:0] MEM_ARB_DATA_BASE  = 32'h0001_0000;
   localparam logic [MEM_ARB_ADDR_W-1:0] MEM_ARB_DATA_TOP   = 32'h0001_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_I_BUSY = 3'd1,
      ST_D_BUSY = 3'd2,
      ST_I_RESP = 3'd3,
      ST_D_RESP = 3'd4
   } mem_arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the fetch requester, data requester and memory port signals.
//   modport master : arbiter view (serves requesters, drives memory port)
//   modport slave  : surroundings view (CPU requesters and memory model)
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ARB_ADDR_W,
   parameter int DATA_W = MEM_ARB_DATA_W
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              wait_instr;
   logic              instr_segv;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              wait_data;
   logic              data_segv;

   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
      output i_rdata, wait_instr, instr_segv, d_rdata, wait_data, data_segv,
             m_req, m_we, m_addr, m_wdata
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
      input  i_rdata, wait_instr, instr_segv, d_rdata, wait_data, data_segv,
             m_req, m_we, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_arb_bounds.sv
// mem_arb_bounds
//   Combinational inclusive range check: ok = BASE <= addr <= TOP.
//   Ports: addr (in), ok (out). Assumes BASE <= TOP.
module mem_arb_bounds #(
   parameter int                ADDR_W = 32,
   parameter logic [ADDR_W-1:0] BASE   = '0,
   parameter logic [ADDR_W-1:0] TOP    = '0
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              ok
);
   // Offset-from-base compare folds both bounds into one unsigned test and
   // avoids a constant comparison when BASE is zero.
   localparam logic [ADDR_W-1:0] SPAN = TOP - BASE;

   logic [ADDR_W-1:0] offset;

   assign offset = addr - BASE;
   assign ok     = (offset <= SPAN);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between instruction fetch and load/store, with
//   segment-bounds checking at grant time.
//   Ports: clk, rst (async, active-high), bus (mem_arbiter_if.master:
//   fetch req/addr/rdata/wait/segv, data req/we/addr/wdata/rdata/wait/segv,
//   memory req/we/addr/wdata/ack/rdata).
//   Optional feature: MEM_ARB_BOUNDS_EN enables the bounds check; when it is
//   undefined every address passes and the segv outputs are tied low.
//
//   state     | meaning
//   ----------+---------------------------------------------------
//   ST_IDLE   | arbitrate pending requests, latch winner
//   ST_I_BUSY | fetch issued to memory, waiting for m_ack
//   ST_D_BUSY | load/store issued to memory, waiting for m_ack
//   ST_I_RESP | fetch completion cycle (data or segv)
//   ST_D_RESP | load/store completion cycle (data or segv)
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int                ADDR_W     = MEM_ARB_ADDR_W,
   parameter int                DATA_W     = MEM_ARB_DATA_W,
   parameter logic [ADDR_W-1:0] INSTR_BASE = MEM_ARB_INSTR_BASE,
   parameter logic [ADDR_W-1:0] INSTR_TOP  = MEM_ARB_INSTR_TOP,
   parameter logic [ADDR_W-1:0] DATA_BASE  = MEM_ARB_DATA_BASE,
   parameter logic [ADDR_W-1:0] DATA_TOP   = MEM_ARB_DATA_TOP
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.master bus
);

   mem_arb_state_t    state_q, state_d;
   logic              last_data_q, last_data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_ok, d_ok;
   logic              mem_busy;

`ifdef MEM_ARB_BOUNDS_EN
   logic segv_q, segv_d;

   mem_arb_bounds #(.ADDR_W(ADDR_W), .BASE(INSTR_BASE), .TOP(INSTR_TOP)) u_instr_bounds (
      .addr (bus.i_addr),
      .ok   (i_ok)
   );

   mem_arb_bounds #(.ADDR_W(ADDR_W), .BASE(DATA_BASE), .TOP(DATA_TOP)) u_data_bounds (
      .addr (bus.d_addr),
      .ok   (d_ok)
   );
`else
   assign i_ok = 1'b1;
   assign d_ok = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         last_data_q <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef MEM_ARB_BOUNDS_EN
         segv_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_data_q <= last_data_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_BOUNDS_EN
         segv_q      <= segv_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      last_data_d = last_data_q;
      addr_d      = addr_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_BOUNDS_EN
      segv_d      = segv_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            // Data wins when it is alone or when fetch was granted last.
            if (bus.d_req && (!bus.i_req || !last_data_q)) begin
               last_data_d = 1'b1;
               addr_d      = bus.d_addr;
               we_d        = bus.d_we;
               wdata_d     = bus.d_wdata;
               state_d     = d_ok ? ST_D_BUSY : ST_D_RESP;
`ifdef MEM_ARB_BOUNDS_EN
               segv_d      = !d_ok;
`endif
            end else if (bus.i_req) begin
               last_data_d = 1'b0;
               addr_d      = bus.i_addr;
               we_d        = 1'b0;
               wdata_d     = '0;
               state_d     = i_ok ? ST_I_BUSY : ST_I_RESP;
`ifdef MEM_ARB_BOUNDS_EN
               segv_d      = !i_ok;
`endif
            end
         end
         ST_I_BUSY: begin
            if (bus.m_ack) begin
               i_rdata_d = bus.m_rdata;
               state_d   = ST_I_RESP;
            end
         end
         ST_D_BUSY: begin
            if (bus.m_ack) begin
               if (!we_q) d_rdata_d = bus.m_rdata;
               state_d = ST_D_RESP;
            end
         end
         ST_I_RESP: state_d = ST_IDLE;
         ST_D_RESP: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign mem_busy    = (state_q == ST_I_BUSY) || (state_q == ST_D_BUSY);
   assign bus.m_req   = mem_busy;
   assign bus.m_we    = mem_busy & we_q;
   assign bus.m_addr  = addr_q;
   assign bus.m_wdata = wdata_q;

   assign bus.i_rdata    = i_rdata_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.wait_instr = bus.i_req & (state_q != ST_I_RESP);
   assign bus.wait_data  = bus.d_req & (state_q != ST_D_RESP);

`ifdef MEM_ARB_BOUNDS_EN
   assign bus.instr_segv = (state_q == ST_I_RESP) & segv_q;
   assign bus.data_segv  = (state_q == ST_D_RESP) & segv_q;
`else
   assign bus.instr_segv = 1'b0;
   assign bus.data_segv  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter: reset, fetch latency, tie/alternate,
//   store latching, segv (both builds of MEM_ARB_BOUNDS_EN), reset abort.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   int   errs;
   int   checks;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_mreq();
      int n = 0;
      while (bus.m_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk_val("m_req_seen", {31'd0, bus.m_req}, 32'd1);
   endtask

   task automatic ack_now(input logic [31:0] data);
      bus.m_rdata = data;
      bus.m_ack   = 1'b1;
      tick();
      bus.m_ack   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] tie_addr [3];
      logic [31:0] tie_data [3];
      logic        is_d;

      errs   = 0;
      checks = 0;
      rst          = 1'b1;
      bus.i_req    = 1'b1;
      bus.i_addr   = 32'h10;
      bus.d_req    = 1'b0;
      bus.d_we     = 1'b0;
      bus.d_addr   = '0;
      bus.d_wdata  = '0;
      bus.m_ack    = 1'b0;
      bus.m_rdata  = '0;

      // reset state
      tick();
      tick();
      chk_val("rst_m_req",   {31'd0, bus.m_req}, 32'd0);
      chk_val("rst_wait_i",  {31'd0, bus.wait_instr}, 32'd1);
      chk_val("rst_i_rdata", bus.i_rdata, 32'd0);
      chk_val("rst_d_rdata", bus.d_rdata, 32'd0);
      chk_val("rst_m_addr",  bus.m_addr, 32'd0);
      chk_val("rst_segv",    {30'd0, bus.instr_segv, bus.data_segv}, 32'd0);

      // fetch, ack 3 cycles after m_req
      rst = 1'b0;
      tick();
      chk_val("f_m_req_c1", {31'd0, bus.m_req}, 32'd1);
      chk_val("f_m_addr",   bus.m_addr, 32'h10);
      chk_val("f_m_we_c1",  {31'd0, bus.m_we}, 32'd0);
      tick();
      chk_val("f_m_we_c2",  {31'd0, bus.m_we}, 32'd0);
      chk_val("f_wait_c2",  {31'd0, bus.wait_instr}, 32'd1);
      tick();
      tick();
      chk_val("f_wait_c4",  {31'd0, bus.wait_instr}, 32'd1);
      chk_val("f_m_req_c4", {31'd0, bus.m_req}, 32'd1);
      ack_now(32'hDEADBEEF);
      chk_val("f_wait_c5",  {31'd0, bus.wait_instr}, 32'd0);
      chk_val("f_i_rdata",  bus.i_rdata, 32'hDEADBEEF);
      chk_val("f_m_req_c5", {31'd0, bus.m_req}, 32'd0);
      tick();
      chk_val("f_wait_c6",  {31'd0, bus.wait_instr}, 32'd1);
      bus.i_req = 1'b0;
      tick();
      chk_val("f_idle_m_req", {31'd0, bus.m_req}, 32'd0);

      // tie from reset, then alternate
      rst         = 1'b1;
      bus.i_req   = 1'b1;
      bus.d_req   = 1'b1;
      bus.i_addr  = 32'h20;
      bus.d_addr  = 32'h0001_0008;
      bus.d_we    = 1'b0;
      tick();
      rst = 1'b0;
      tie_addr[0] = 32'h0001_0008; tie_data[0] = 32'h1111;
      tie_addr[1] = 32'h20;        tie_data[1] = 32'h2222;
      tie_addr[2] = 32'h0001_0008; tie_data[2] = 32'h3333;
      for (int t = 0; t < 3; t++) begin
         is_d = (t != 1);
         wait_mreq();
         chk_val("tie_addr", bus.m_addr, tie_addr[t]);
         ack_now(tie_data[t]);
         chk_val("tie_wait_i", {31'd0, bus.wait_instr}, is_d ? 32'd1 : 32'd0);
         chk_val("tie_wait_d", {31'd0, bus.wait_data},  is_d ? 32'd0 : 32'd1);
         chk_val("tie_rdata", is_d ? bus.d_rdata : bus.i_rdata, tie_data[t]);
         tick();
      end
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
      tick();

      // store with wdata changing mid-transaction
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b1;
      bus.d_addr  = 32'h0001_0004;
      bus.d_wdata = 32'h55;
      wait_mreq();
      chk_val("st_m_we",    {31'd0, bus.m_we}, 32'd1);
      chk_val("st_m_addr",  bus.m_addr, 32'h0001_0004);
      chk_val("st_m_wdata", bus.m_wdata, 32'h55);
      bus.d_wdata = 32'hAA;
      bus.d_addr  = 32'h0001_0000;
      tick();
      chk_val("st_m_wdata_hold", bus.m_wdata, 32'h55);
      chk_val("st_m_addr_hold",  bus.m_addr, 32'h0001_0004);
      ack_now(32'h0BAD);
      chk_val("st_wait_d",  {31'd0, bus.wait_data}, 32'd0);
      chk_val("st_d_rdata", bus.d_rdata, 32'h3333);
      bus.d_req = 1'b0;
      bus.d_we  = 1'b0;
      tick();

      // out-of-range data access
      bus.d_req  = 1'b1;
      bus.d_addr = 32'h0002_0000;
      tick();
`ifdef MEM_ARB_BOUNDS_EN
      chk_val("sv_d_m_req",  {31'd0, bus.m_req}, 32'd0);
      chk_val("sv_d_segv",   {31'd0, bus.data_segv}, 32'd1);
      chk_val("sv_d_wait",   {31'd0, bus.wait_data}, 32'd0);
      chk_val("sv_d_rdata",  bus.d_rdata, 32'h3333);
      bus.d_req = 1'b0;
      tick();
      chk_val("sv_d_segv_clr", {31'd0, bus.data_segv}, 32'd0);
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h0001_0000;
      tick();
      chk_val("sv_i_m_req", {31'd0, bus.m_req}, 32'd0);
      chk_val("sv_i_segv",  {31'd0, bus.instr_segv}, 32'd1);
      chk_val("sv_i_wait",  {31'd0, bus.wait_instr}, 32'd0);
      chk_val("sv_i_rdata", bus.i_rdata, 32'h2222);
      bus.i_req = 1'b0;
      tick();
`else
      chk_val("nsv_m_req", {31'd0, bus.m_req}, 32'd1);
      chk_val("nsv_m_addr", bus.m_addr, 32'h0002_0000);
      ack_now(32'h4444);
      chk_val("nsv_segv",   {31'd0, bus.data_segv}, 32'd0);
      chk_val("nsv_wait",   {31'd0, bus.wait_data}, 32'd0);
      chk_val("nsv_rdata",  bus.d_rdata, 32'h4444);
      bus.d_req = 1'b0;
      tick();
`endif

      // reset abort while in I_BUSY, late ack ignored
      rst        = 1'b1;
      bus.i_req  = 1'b1;
      bus.i_addr = 32'h40;
      tick();
      rst = 1'b0;
      tick();
      chk_val("ab_m_req_busy", {31'd0, bus.m_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk_val("ab_m_req_rst", {31'd0, bus.m_req}, 32'd0);
      chk_val("ab_wait_rst",  {31'd0, bus.wait_instr}, 32'd1);
      #1;
      rst = 1'b0;
      ack_now(32'h77);
      chk_val("ab_m_req_regrant", {31'd0, bus.m_req}, 32'd1);
      chk_val("ab_wait_late",     {31'd0, bus.wait_instr}, 32'd1);
      chk_val("ab_i_rdata",       bus.i_rdata, 32'd0);
      ack_now(32'h99);
      chk_val("ab_done_wait",  {31'd0, bus.wait_instr}, 32'd0);
      chk_val("ab_done_rdata", bus.i_rdata, 32'h99);
      bus.i_req = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
